aes_out_buffer: RTL and testbench



---
 rtl/aes_out_buffer_if.sv | 36 +++
 rtl/aes_out_buffer.sv | 114 +++++++++++
 tb/tb_aes_out_buffer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_out_buffer_if.sv
// Handshake bundle between the AES core issue/result ports and the result collector.
// Optional OUT_TAG member exists only when AES_OUT_BUFFER_TAG_EN is defined.
interface aes_out_buffer_if #(
  parameter int WIDTH = 128
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] PIPE_OUT;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] OUT_DATA;
  logic             OVF_ERR;
`ifdef AES_OUT_BUFFER_TAG_EN
  logic [15:0]      OUT_TAG;

  modport slave (
    input  IN_VALID, PIPE_OUT, OUT_READY,
    output IN_READY, OUT_VALID, OUT_DATA, OVF_ERR, OUT_TAG
  );

  modport master (
    output IN_VALID, PIPE_OUT, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_DATA, OVF_ERR, OUT_TAG
  );
`else
  modport slave (
    input  IN_VALID, PIPE_OUT, OUT_READY,
    output IN_READY, OUT_VALID, OUT_DATA, OVF_ERR
  );

  modport master (
    output IN_VALID, PIPE_OUT, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_DATA, OVF_ERR
  );
`endif
endinterface

// File: rtl/aes_out_buffer.sv
// Latency-matched, credit-gated result FIFO behind the fixed-latency AES-256 core.
// Define AES_OUT_BUFFER_TAG_EN to add a 16-bit per-result issue index on OUT_TAG.
module aes_out_buffer #(
  parameter int LATENCY = 82,
  parameter int DEPTH   = 128,
  parameter int WIDTH   = 128
) (
  input  logic            CLK,
  input  logic            RST,
  aes_out_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(LATENCY + 1);
  localparam int SW = ((CW > IW) ? CW : IW) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [SW-1:0] CREDITS  = SW'(DEPTH);

  logic [LATENCY-1:0] vpipe;
  logic [IW-1:0]      inflight;
  logic [CW-1:0]      count;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               ovf;
  logic [WIDTH-1:0]   mem [DEPTH];

  logic issue;
  logic tap;
  logic full;
  logic pop;
  logic push;

  assign tap   = vpipe[LATENCY-1];
  assign full  = (count == FULL_CNT);
  assign pop   = (count != '0) & bus.OUT_READY;
  // A full FIFO can still accept a capture when the head leaves on the same edge.
  assign push  = tap & (~full | pop);
  assign issue = bus.IN_VALID & bus.IN_READY;

  // Credits cover both stored results and results still inside the core.
  assign bus.IN_READY  = ~RST & ((SW'(count) + SW'(inflight)) < CREDITS);
  assign bus.OUT_VALID = (count != '0);
  assign bus.OUT_DATA  = mem[rd_ptr];
  assign bus.OVF_ERR   = ovf;

  always_ff @(posedge CLK) begin
    if (RST) begin
      vpipe    <= '0;
      inflight <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ovf      <= 1'b0;
    end else begin
      // Issue slot marker travels alongside the core's internal pipeline.
      vpipe[0] <= issue;
      for (int k = 1; k < LATENCY; k++) begin
        vpipe[k] <= vpipe[k-1];
      end

      case ({issue, tap})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (tap && full && !pop) begin
        ovf <= 1'b1;
      end
    end
  end

  // Result storage is data-only and intentionally left unreset.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= bus.PIPE_OUT;
    end
  end

`ifdef AES_OUT_BUFFER_TAG_EN
  logic [15:0] tag_cnt;
  logic [15:0] tag_mem [DEPTH];

  // Counts every tapped slot, so a tag equals the issue index since reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tag_cnt <= '0;
    end else if (tap) begin
      tag_cnt <= tag_cnt + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      tag_mem[wr_ptr] <= tag_cnt;
    end
  end

  assign bus.OUT_TAG = tag_mem[rd_ptr];
`endif

endmodule

// File: tb/tb_aes_out_buffer.sv
// Scoreboard bench for aes_out_buffer with a delay-line stand-in for the AES core.
// Stimulus drives #1 after the rising edge; all observation happens on the falling edge.
module tb_aes_out_buffer;
  localparam int L = 5;
  localparam int D = 8;
  localparam int W = 128;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  aes_out_buffer_if #(.WIDTH(W)) bus ();

  aes_out_buffer #(.LATENCY(L), .DEPTH(D), .WIDTH(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Core stand-in: whatever sits on the inputs reappears L edges later, valid or not.
  logic [W-1:0] in_data;
  logic [W-1:0] cpipe [L];
  always @(posedge CLK) begin
    cpipe[0] <= in_data;
    for (int k = 1; k < L; k++) cpipe[k] <= cpipe[k-1];
  end
  assign bus.PIPE_OUT = cpipe[L-1];

  int n_cmp = 0;
  int n_fail = 0;
  int n_pop = 0;
  int run = 0;
  int max_run = 0;
  logic [W-1:0] exp_q[$];
`ifdef AES_OUT_BUFFER_TAG_EN
  logic [15:0] tag_q[$];
  logic [15:0] tag_ctr = '0;
`endif

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] token(input int i);
    return {32'hA0E5_0000 ^ 32'(i), 32'(i * 7 + 1), 32'hDEAD_0000 | 32'(i), ~32'(i)};
  endfunction

  function automatic logic [W-1:0] garbage();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(input string name, input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      step();
      c++;
    end
    check_int({name, "_drained"}, exp_q.size(), 0);
  endtask

  // Monitor: record issues into the scoreboard and compare every popped head.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge CLK);
      if (RST) begin
        exp_q.delete();
        run = 0;
`ifdef AES_OUT_BUFFER_TAG_EN
        tag_q.delete();
        tag_ctr = '0;
`endif
      end else begin
        if (bus.IN_VALID && bus.IN_READY) begin
          exp_q.push_back(in_data);
`ifdef AES_OUT_BUFFER_TAG_EN
          tag_q.push_back(tag_ctr);
          tag_ctr = tag_ctr + 16'd1;
`endif
        end
        if (bus.OUT_VALID) run++;
        else run = 0;
        if (run > max_run) max_run = run;
        if (bus.OUT_VALID && bus.OUT_READY) begin
          n_pop++;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_out: got %h, expected no result", bus.OUT_DATA);
          end else begin
            e = exp_q.pop_front();
            if (bus.OUT_DATA !== e) begin
              n_fail++;
              $display("FAIL out_data: got %h, expected %h", bus.OUT_DATA, e);
            end
`ifdef AES_OUT_BUFFER_TAG_EN
            check_int("out_tag", int'(bus.OUT_TAG), int'(tag_q.pop_front()));
`endif
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int acc;
    int p0;
    int vcnt;
    bit found;

    bus.IN_VALID  = 1'b0;
    bus.OUT_READY = 1'b1;
    in_data       = '0;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_bit("rst_in_ready", bus.IN_READY, 1'b0);
    check_bit("rst_out_valid", bus.OUT_VALID, 1'b0);
    check_bit("rst_ovf", bus.OVF_ERR, 1'b0);
    step();
    RST = 1'b0;
    @(negedge CLK);
    check_bit("post_rst_in_ready", bus.IN_READY, 1'b1);

    // Single issue: capture at the L-th edge after the issue edge
    step();
    bus.IN_VALID = 1'b1;
    in_data      = 128'h8ea2b7ca516745befafc49904b496089;
    step();
    bus.IN_VALID = 1'b0;
    in_data      = garbage();
    lat   = 0;
    found = 1'b0;
    for (int c = 1; c <= L + 10 && !found; c++) begin
      @(posedge CLK);
      in_data = garbage();
      @(negedge CLK);
      if (bus.OUT_VALID) begin
        lat   = c;
        found = 1'b1;
      end
    end
    check_int("issue_to_valid_edges", lat, L);
    @(posedge CLK);
    @(negedge CLK);
    check_bit("single_out_valid_low", bus.OUT_VALID, 1'b0);
    drain("single", 5);

    // Back-to-back issues with OUT_READY held high
    step();
    max_run = 0;
    p0 = n_pop;
    for (int i = 0; i < 60; i++) begin
      bus.IN_VALID = 1'b1;
      in_data      = token(i);
      @(negedge CLK);
      check_bit("b2b_in_ready", bus.IN_READY, 1'b1);
      step();
    end
    bus.IN_VALID = 1'b0;
    in_data      = garbage();
    drain("b2b", L + 20);
    check_int("b2b_pops", n_pop - p0, 60);
    check_int("b2b_no_gaps", max_run, 60);

    // Fill to credit limit with the sink stalled
    bus.OUT_READY = 1'b0;
    acc = 0;
    p0  = n_pop;
    for (int i = 0; i < 20; i++) begin
      bus.IN_VALID = 1'b1;
      in_data      = token(100 + i);
      @(negedge CLK);
      if (bus.IN_READY) acc++;
      step();
    end
    bus.IN_VALID = 1'b0;
    in_data      = garbage();
    check_int("full_accepted", acc, D);
    @(negedge CLK);
    check_bit("full_in_ready", bus.IN_READY, 1'b0);
    check_bit("full_out_valid", bus.OUT_VALID, 1'b1);
    check_bit("full_ovf", bus.OVF_ERR, 1'b0);
    step();
    bus.OUT_READY = 1'b1;
    @(negedge CLK);
    check_bit("prepop_in_ready", bus.IN_READY, 1'b0);
    @(posedge CLK);
    @(negedge CLK);
    check_bit("postpop_in_ready", bus.IN_READY, 1'b1);
    drain("full", 30);
    check_int("full_pops", n_pop - p0, D);

    // Alternating issue with a randomly stalling sink
    step();
    for (int i = 0; i < 40; i++) begin
      bus.IN_VALID  = (i % 2 == 0);
      in_data       = (i % 2 == 0) ? token(200 + i) : garbage();
      bus.OUT_READY = 1'($urandom_range(0, 1));
      step();
    end
    bus.IN_VALID  = 1'b0;
    in_data       = garbage();
    bus.OUT_READY = 1'b1;
    drain("alt", 80);
    check_bit("alt_ovf", bus.OVF_ERR, 1'b0);

    // Reset with results both queued and still in the core
    bus.OUT_READY = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.IN_VALID = 1'b1;
      in_data      = token(300 + i);
      step();
    end
    bus.IN_VALID = 1'b0;
    in_data      = garbage();
    RST          = 1'b1;
    bus.OUT_READY = 1'b1;
    @(negedge CLK);
    check_bit("midrst_fifo_nonempty", bus.OUT_VALID, 1'b1);
    check_bit("midrst_in_ready", bus.IN_READY, 1'b0);
    step();
    RST = 1'b0;
    @(negedge CLK);
    check_bit("midrst_out_valid", bus.OUT_VALID, 1'b0);
    check_bit("midrst_in_ready_after", bus.IN_READY, 1'b1);
    vcnt = 0;
    repeat (L + 4) begin
      @(posedge CLK);
      @(negedge CLK);
      if (bus.OUT_VALID) vcnt++;
    end
    check_int("midrst_stale_results", vcnt, 0);

    // Normal operation resumes after reset
    step();
    p0 = n_pop;
    for (int i = 0; i < 3; i++) begin
      bus.IN_VALID = 1'b1;
      in_data      = token(400 + i);
      step();
    end
    bus.IN_VALID = 1'b0;
    in_data      = garbage();
    drain("post_rst", L + 10);
    check_int("post_rst_pops", n_pop - p0, 3);
    check_bit("final_ovf", bus.OVF_ERR, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
